// File: rtl/montgomery_mul_pipe.sv
// rtl/montgomery_mul_pipe.sv - streaming Montgomery multiplier (MUL/SQR/TO_MONT/FROM_MONT)
// Operand capture rank plus four arithmetic ranks, all held together on output backpressure.
module montgomery_mul_pipe #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] N        = 64'hFFFFFFFFFFFFFFF1,
    parameter logic [WIDTH-1:0] N_PRIME  = 64'hEEEEEEEEEEEEEEEF,
    parameter logic [WIDTH-1:0] R2_MOD_N = 64'hE1,
    parameter int               TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [1:0] OP_MUL       = 2'b00;
    localparam logic [1:0] OP_TO_MONT   = 2'b01;
    localparam logic [1:0] OP_FROM_MONT = 2'b10;
    localparam logic [1:0] OP_SQR       = 2'b11;

    logic advance;

    // rank 0: selected operands
    logic               s0_valid_q, s0_err_q;
    logic [TAG_W-1:0]   s0_tag_q;
    logic [WIDTH-1:0]   s0_x_q, s0_y_q;
    logic [WIDTH-1:0]   s0_x_d, s0_y_d;
    logic               s0_err_d;

    // rank 1: full product T
    logic               s1_valid_q, s1_err_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic [2*WIDTH-1:0] s1_t_q, s1_t_d;

    // rank 2: reduction factor m, T carried forward
    logic               s2_valid_q, s2_err_q;
    logic [TAG_W-1:0]   s2_tag_q;
    logic [2*WIDTH-1:0] s2_t_q;
    logic [WIDTH-1:0]   s2_m_q, s2_m_d;

    // rank 3: u = (T + m*N) >> W
    logic               s3_valid_q, s3_err_q;
    logic [TAG_W-1:0]   s3_tag_q;
    logic [WIDTH:0]     s3_u_q, s3_u_d;
    logic [2*WIDTH:0]   s3_sum;

    // rank 4: output register
    logic               out_valid_q, out_err_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic [WIDTH:0]     s4_diff;

    logic unused_bits;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        s0_x_d = in_a;
        s0_y_d = in_b;
        case (in_op)
            OP_MUL:       s0_y_d = in_b;
            OP_SQR:       s0_y_d = in_a;
            OP_TO_MONT:   s0_y_d = R2_MOD_N;
            OP_FROM_MONT: s0_y_d = {{(WIDTH-1){1'b0}}, 1'b1};
            default:      s0_y_d = in_b;
        endcase
        s0_err_d = (in_a >= N) || ((in_op == OP_MUL) && (in_b >= N));
    end

    assign s1_t_d = {{WIDTH{1'b0}}, s0_x_q} * {{WIDTH{1'b0}}, s0_y_q};
    assign s2_m_d = s1_t_q[WIDTH-1:0] * N_PRIME;

    // The sum is one bit wider than T so the carry out of bit 2W-1 lands in u.
    assign s3_sum = {1'b0, s2_t_q}
                  + ({{(WIDTH+1){1'b0}}, s2_m_q} * {{(WIDTH+1){1'b0}}, N});
    assign s3_u_d = s3_sum[2*WIDTH:WIDTH];

    assign s4_diff      = s3_u_q - {1'b0, N};
    assign out_result_d = (s3_u_q >= {1'b0, N}) ? s4_diff[WIDTH-1:0] : s3_u_q[WIDTH-1:0];

    // Low half of the sum is zero by construction and the final result always fits in W bits.
    assign unused_bits = ^{s3_sum[WIDTH-1:0], s4_diff[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q   <= 1'b0;
            s0_err_q     <= 1'b0;
            s0_tag_q     <= '0;
            s0_x_q       <= '0;
            s0_y_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_tag_q     <= '0;
            s1_t_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_err_q     <= 1'b0;
            s2_tag_q     <= '0;
            s2_t_q       <= '0;
            s2_m_q       <= '0;
            s3_valid_q   <= 1'b0;
            s3_err_q     <= 1'b0;
            s3_tag_q     <= '0;
            s3_u_q       <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            out_result_q <= '0;
        end else if (advance) begin
            s0_valid_q   <= in_valid;
            s0_err_q     <= s0_err_d;
            s0_tag_q     <= in_tag;
            s0_x_q       <= s0_x_d;
            s0_y_q       <= s0_y_d;

            s1_valid_q   <= s0_valid_q;
            s1_err_q     <= s0_err_q;
            s1_tag_q     <= s0_tag_q;
            s1_t_q       <= s1_t_d;

            s2_valid_q   <= s1_valid_q;
            s2_err_q     <= s1_err_q;
            s2_tag_q     <= s1_tag_q;
            s2_t_q       <= s1_t_q;
            s2_m_q       <= s2_m_d;

            s3_valid_q   <= s2_valid_q;
            s3_err_q     <= s2_err_q;
            s3_tag_q     <= s2_tag_q;
            s3_u_q       <= s3_u_d;

            out_valid_q  <= s3_valid_q;
            out_err_q    <= s3_err_q;
            out_tag_q    <= s3_tag_q;
            out_result_q <= out_result_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;
    assign out_tag    = out_tag_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_montgomery_mul_pipe.sv
// tb/tb_montgomery_mul_pipe.sv - self-checking bench for montgomery_mul_pipe
module tb_montgomery_mul_pipe;

    localparam logic [63:0] NMOD = 64'hFFFFFFFFFFFFFFF1;
    localparam logic [63:0] R2   = 64'hE1;
    localparam logic [1:0]  MUL = 2'b00, TOM = 2'b01, FROMM = 2'b10, SQR = 2'b11;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0]  in_op;
    logic [63:0] in_a, in_b, out_result;
    logic [7:0]  in_tag, out_tag;

    montgomery_mul_pipe #(.WIDTH(64), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [7:0]  tag;
        logic        err;
        int          edge_n;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          ovr_en = 1'b0;
    logic [63:0] ovr_res;
    logic        ovr_err;
    logic [63:0] rinv;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_res;
    logic [7:0]  prev_tag;
    logic        prev_err;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // x*y*R^-1 mod N computed directly with wide modular arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  y;
        logic [127:0] p, r;
        logic         e;
        case (op)
            MUL:     y = b;
            SQR:     y = a;
            TOM:     y = R2;
            default: y = 64'd1;
        endcase
        e = (a >= NMOD) || (op == MUL && b >= NMOD);
        p = ({64'd0, a} * {64'd0, y}) % {64'd0, NMOD};
        r = (p * {64'd0, rinv}) % {64'd0, NMOD};
        return {e, r[63:0]};
    endfunction

    function automatic logic [63:0] rand_in_range();
        logic [63:0] v;
        v = {$urandom, $urandom};
        while (v >= NMOD) v = {$urandom, $urandom};
        return v;
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] tg, input logic ordy, output logic fired);
        exp_t        e;
        logic [64:0] m;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tg;
        out_ready = ordy;
        #4;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (prev_stall) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", out_result, prev_res);
            chk("stall_tag", {56'd0, out_tag}, {56'd0, prev_tag});
            chk("stall_err", {63'd0, out_err}, {63'd0, prev_err});
        end
        fired = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("out_tag", {56'd0, out_tag}, {56'd0, e.tag});
                chk("out_err", {63'd0, out_err}, {63'd0, e.err});
                if (!e.err) chk("out_result", out_result, e.res);
                if (lat_chk) chk("latency", 64'(cyc - e.edge_n), 64'd4);
            end
        end
        if (fired) begin
            if (ovr_en) q.push_back('{ovr_res, tg, ovr_err, cyc + 1});
            else begin
                m = model(op, a, b);
                q.push_back('{m[63:0], tg, m[64], cyc + 1});
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_tag   = out_tag;
        prev_err   = out_err;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue_exp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [7:0] tg, input logic [63:0] res, input logic err);
        logic f;
        int   n;
        ovr_en  = 1'b1;
        ovr_res = res;
        ovr_err = err;
        f = 1'b0;
        n = 0;
        while (!f && n < 50) begin
            step(1'b1, op, a, b, tg, 1'b1, f);
            n++;
        end
        ovr_en = 1'b0;
        if (!f) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input bit rnd);
        logic f;
        int   n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            step(1'b0, MUL, 64'd0, 64'd0, 8'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, f);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] v;
        logic [63:0] a, b;
        logic [1:0]  op;
        logic        f;
        int          cnt, guard;

        // R^-1 mod N by halving 1 modulo N, W times
        v = 65'd1;
        repeat (64) v = v[0] ? ((v + {1'b0, NMOD}) >> 1) : (v >> 1);
        rinv = v[63:0];

        rst_n = 1'b0;
        in_valid = 1'b0; in_op = MUL; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        lat_chk = 1'b1;
        issue_exp(TOM, 64'd2, 64'd0, 8'h10, 64'h1E, 1'b0);
        drain(0);
        issue_exp(FROMM, 64'h1E, 64'd0, 8'h11, 64'd2, 1'b0);
        drain(0);

        issue_exp(MUL, 64'h1E, 64'h2D, 8'h20, 64'h5A, 1'b0);
        issue_exp(TOM, 64'd2, 64'd0, 8'd1, 64'h1E, 1'b0);
        issue_exp(TOM, 64'd3, 64'd0, 8'd2, 64'h2D, 1'b0);
        issue_exp(TOM, 64'd6, 64'd0, 8'd3, 64'h5A, 1'b0);
        drain(0);

        issue_exp(TOM, 64'hFFFFFFFFFFFFFFF0, 64'd0, 8'h30, 64'hFFFFFFFFFFFFFFE2, 1'b0);
        issue_exp(SQR, 64'hFFFFFFFFFFFFFFE2, 64'd0, 8'h31, 64'hF, 1'b0);
        issue_exp(FROMM, 64'hFFFFFFFFFFFFFFE2, 64'd0, 8'h32, 64'hFFFFFFFFFFFFFFF0, 1'b0);
        drain(0);

        issue_exp(MUL, NMOD, 64'd1, 8'h55, 64'd0, 1'b1);
        issue_exp(MUL, 64'd1, 64'd1, 8'h56, rinv, 1'b0);
        drain(0);

        lat_chk = 1'b0;
        cnt = 0; guard = 0;
        a = rand_in_range(); b = rand_in_range();
        while (cnt < 10 && guard < 300) begin
            step(1'b1, MUL, a, b, 8'(8'h60 + cnt), 1'($urandom_range(0, 1)), f);
            if (f) begin
                cnt++;
                a = rand_in_range();
                b = rand_in_range();
            end
            guard++;
        end
        if (cnt != 10) chk("bp_issue_count", 64'(cnt), 64'd10);
        drain(1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? NMOD + 64'($urandom_range(0, 14)) : rand_in_range();
            b  = ($urandom_range(0, 9) == 0) ? NMOD : rand_in_range();
            step(1'($urandom_range(0, 1)), op, a, b, 8'($urandom), 1'($urandom_range(0, 1)), f);
        end
        drain(1);

        step(1'b1, TOM, 64'd4, 64'd0, 8'h70, 1'b0, f);
        step(1'b1, TOM, 64'd5, 64'd0, 8'h71, 1'b0, f);
        step(1'b1, TOM, 64'd7, 64'd0, 8'h72, 1'b0, f);
        for (int i = 0; i < 3; i++) step(1'b0, MUL, 64'd0, 64'd0, 8'd0, 1'b0, f);
        #2;
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_tag", {56'd0, out_tag}, 64'd0);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, MUL, 64'd0, 64'd0, 8'd0, 1'b1, f);
        lat_chk = 1'b1;
        issue_exp(TOM, 64'd1, 64'd0, 8'h80, 64'hF, 1'b0);
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/montgomery_mul_pipe.md
# montgomery_mul_pipe

Parametrised, fully pipelined Montgomery modular multiplier with a valid/ready stream interface. It accepts one operation per cycle and runs it through a 4-stage pipeline with global stall on backpressure. A per-operation mode selects:
- Montgomery multiply
- square
- conversion into Montgomery form
- conversion out of Montgomery form

It is the width-generic, flow-controlled successor to the fixed 64-bit convert/multiply/convert chain, and is used wherever modular products are streamed between arithmetic engines.

## Interface
- WIDTH, 64: operand width W; R = 2^W.
- N, 64'hFFFFFFFFFFFFFFF1: modulus. Must be odd, 3 ≤ N < 2^W.
- N_PRIME, 64'hEEEEEEEEEEEEEEEF: −N⁻¹ mod R, so that N·N_PRIME ≡ −1 (mod R).
- R2_MOD_N, 64'hE1: R² mod N.
- TAG_W, 8: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted on a cycle with in_valid && in_ready.
- in_op  in  2  mode: 00 MUL, 01 TO_MONT, 10 FROM_MONT, 11 SQR.
- in_a  in  WIDTH  first operand.
- in_b  in  WIDTH  second operand; used by MUL only.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_result  out  WIDTH  reduced result, in [0, N).
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  an operand was out of range.

## Operation
- Operand selection, as (x, y):
  - MUL: (a, b)
  - SQR: (a, a)
  - TO_MONT: (a, R2_MOD_N)
  - FROM_MONT: (a, 1)
- Result = x·y·R⁻¹ mod N.
- Stage 1: register T = x·y (2W bits). Register err = (a ≥ N) || (op == MUL && b ≥ N).
- Stage 2: m = (T mod R)·N_PRIME mod R (W bits). T is carried forward.
- Stage 3: u = (T + m·N) >> W.
  - The sum is computed at 2W+1 bits. The carry out of bit 2W−1 must be kept.
  - u is W+1 bits; u < 2N is guaranteed for in-range operands.
- Stage 4: out_result = (u ≥ N) ? u − N : u, with the compare and subtract done at W+1 bits.
- Tag, err and a valid bit travel with every stage.
- When err = 1, out_result is don't-care but the operation still flows through and is tagged. No other side effects.
- Flow control:
  - advance = !out_valid || out_ready.
  - All stage registers load only when advance = 1; otherwise every stage holds.
  - in_ready = advance. The same-cycle out_ready → in_ready combinational path is allowed.
- Bubbles (valid = 0) propagate normally. They do not compress unless advance = 1.

## Timing
- Latency: an op accepted at edge k has out_valid = 1 after edge k+4, provided advance held throughout. Each stall cycle adds one cycle.
- Throughput: one op per cycle while out_ready = 1.
- Output register holds out_result, out_tag and out_err stable while out_valid && !out_ready.
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear; out_valid = 0.
  - out_result = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 immediately, since out_valid = 0.
- Reset mid-operation: all in-flight ops are discarded, with no partial output. The first op accepted after deassertion has the normal 4-cycle latency.
- Simultaneous output handshake and input acceptance in the same cycle is legal and required for full throughput.
- Data, tag and op inputs are ignored when in_valid = 0. Output fields are don't-care when out_valid = 0, except after reset.
- All parameter-dependent arithmetic uses unsigned widths exactly as above; no truncation is permitted before the final subtract.

## Test plan
All scenarios use default parameters (W = 64, N = 2^64 − 15, R mod N = 15).
- TO_MONT a=2 → out_result=0x1E. FROM_MONT a=0x1E → 2. Both with out_err=0 and latency exactly 4.
- MUL a=0x1E, b=0x2D (2R, 3R) → out_result=0x5A (6R). Back-to-back TO_MONT of 2, 3 and 6 are issued with tags 1, 2, 3, and tags must return in order.
- Carry/boundary:
  - TO_MONT a=0xFFFFFFFFFFFFFFF0 → 0xFFFFFFFFFFFFFFE2.
  - SQR a=0xFFFFFFFFFFFFFFE2 → 0xF.
  - FROM_MONT 0xFFFFFFFFFFFFFFE2 → 0xFFFFFFFFFFFFFFF0.
- Backpressure: stream 10 random in-range MULs with in_valid always 1 and out_ready toggled randomly. Results must match the golden model in order, with no drop or duplicate, and the output must be stable while stalled.
- Range error: MUL a=N, b=1 → out_err=1 with its tag. A following MUL a=1, b=1 must give out_result=R⁻¹ mod N with out_err=0.
- Reset: assert rst_n low with 3 ops in flight. out_valid must drop asynchronously and in_ready=1. After release, a single TO_MONT a=1 → 0xF, 4 cycles after acceptance.
